// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types, opcodes, program start table and branch target LUT for instr_fetch
package fetch_pkg;
    localparam int PC_W    = 10;
    localparam int INSTR_W = 9;
    localparam int LUT_W   = 5;
    localparam int PSEL_W  = 2;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [INSTR_W-1:0] NOP  = '0;
    localparam logic [INSTR_W-1:0] HALT = '1;

    // encode, decode, burst-decode, spare
    localparam logic [PC_W-1:0] START_ADDR [2**PSEL_W] = '{
        10'h000, 10'h080, 10'h100, 10'h000
    };

    localparam logic [PC_W-1:0] BRANCH_LUT [2**LUT_W] = '{
        10'h000, 10'h010, 10'h020, 10'h0A0, 10'h0A2, 10'h040, 10'h085, 10'h0A0,
        10'h090, 10'h025, 10'h0C0, 10'h0C8, 10'h0D0, 10'h0D8, 10'h0E0, 10'h0E8,
        10'h110, 10'h118, 10'h120, 10'h128, 10'h130, 10'h138, 10'h140, 10'h148,
        10'h180, 10'h188, 10'h190, 10'h198, 10'h1A0, 10'h1A8, 10'h1B0, 10'h3FF
    };

    // Sequential PC step; wraps modulo 2^PC_W with no flag.
    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + PC_W'(1);
    endfunction
endpackage

// File: rtl/branch_lut.sv
// branch_lut: combinational branch-target lookup
//   i_idx    : LUT index taken from the instruction's low bits
//   o_target : absolute PC of the branch target
module branch_lut
    import fetch_pkg::*;
(
    input  logic [LUT_W-1:0] i_idx,
    output logic [PC_W-1:0]  o_target
);
    assign o_target = BRANCH_LUT[i_idx];
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC, next-PC selection and program start/halt sequencing
//   Clk, Reset_n       : clock, async active-low reset
//   Start, ProgSel     : launch program ProgSel from IDLE or DONE
//   Stall              : hold PC and suppress the instruction this cycle
//   Branch, Zero       : taken branch when both set
//   TargetIdx          : branch LUT index
//   InstrIn / ProgCtr  : combinational ROM data / address
//   Instr, InstrValid  : gated instruction to the decoder
//   Done               : program reached HALT
module instr_fetch
    import fetch_pkg::*;
(
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               Start,
    input  logic [PSEL_W-1:0]  ProgSel,
    input  logic               Stall,
    input  logic               Branch,
    input  logic               Zero,
    input  logic [LUT_W-1:0]   TargetIdx,
    input  logic [INSTR_W-1:0] InstrIn,
    output logic [PC_W-1:0]    ProgCtr,
    output logic [INSTR_W-1:0] Instr,
    output logic               InstrValid,
    output logic               Done
);
    state_t            r_state, w_next_state;
    logic [PC_W-1:0]   r_pc, w_next_pc, w_lut_target;
    logic              w_halt;

    branch_lut u_lut (
        .i_idx    (TargetIdx),
        .o_target (w_lut_target)
    );

    assign w_halt  = InstrIn == HALT;
    assign ProgCtr = r_pc;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
            r_pc    <= '0;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
        end
    end

    // Priority in RUN: stall, then HALT, then taken branch, then increment.
    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        case (r_state)
            IDLE, DONE: begin
                if (Start) begin
                    w_next_state = RUN;
                    w_next_pc    = START_ADDR[ProgSel];
                end
            end
            RUN: begin
                if (!Stall) begin
                    if (w_halt)
                        w_next_state = DONE;
                    else if (Branch && Zero)
                        w_next_pc = w_lut_target;
                    else
                        w_next_pc = pc_inc(r_pc);
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        InstrValid = (r_state == RUN) && !Stall;
        Instr      = InstrValid ? InstrIn : NOP;
        Done       = r_state == DONE;
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scoreboard bench for instr_fetch with directed vectors
module tb_instr_fetch;
    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       Start = 1'b0;
    logic [1:0] ProgSel = '0;
    logic       Stall = 1'b0;
    logic       Branch = 1'b0;
    logic       Zero = 1'b0;
    logic [4:0] TargetIdx = '0;
    logic [8:0] InstrIn;
    logic [9:0] ProgCtr;
    logic [8:0] Instr;
    logic       InstrValid;
    logic       Done;

    localparam logic [8:0] T_NOP  = 9'h000;
    localparam logic [8:0] T_HALT = 9'h1FF;

    typedef struct {
        logic [9:0] pc;
        logic       v;
        logic       d;
        logic [8:0] instr;
        int         id;
    } exp_t;

    exp_t       sb[$];
    logic [8:0] rom [1024];
    int         tests = 0;
    int         fails = 0;
    int         vec = 0;

    always #5 Clk = ~Clk;

    assign InstrIn = rom[ProgCtr];

    instr_fetch dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Start      (Start),
        .ProgSel    (ProgSel),
        .Stall      (Stall),
        .Branch     (Branch),
        .Zero       (Zero),
        .TargetIdx  (TargetIdx),
        .InstrIn    (InstrIn),
        .ProgCtr    (ProgCtr),
        .Instr      (Instr),
        .InstrValid (InstrValid),
        .Done       (Done)
    );

    // Drive one cycle's inputs just after the edge and queue what the outputs must show this cycle.
    task automatic cyc(input logic rn, input logic st, input logic [1:0] ps, input logic sl,
                       input logic br, input logic z, input logic [4:0] ti,
                       input logic [9:0] epc, input logic ev, input logic ed);
        exp_t e;
        @(posedge Clk);
        #1;
        Reset_n = rn; Start = st; ProgSel = ps; Stall = sl;
        Branch = br; Zero = z; TargetIdx = ti;
        e.pc = epc; e.v = ev; e.d = ed;
        e.instr = ev ? rom[epc] : T_NOP;
        e.id = vec;
        vec++;
        sb.push_back(e);
    endtask

    always @(negedge Clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            tests++;
            if (ProgCtr !== e.pc || InstrValid !== e.v || Done !== e.d || Instr !== e.instr) begin
                fails++;
                $display("FAIL vec%0d: got pc=%h v=%b d=%b instr=%h, expected pc=%h v=%b d=%b instr=%h",
                         e.id, ProgCtr, InstrValid, Done, Instr, e.pc, e.v, e.d, e.instr);
            end
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = T_NOP;
        rom[10'h0A2] = T_HALT;
        //   rn st ps  sl br z  ti     pc      v  d
        cyc(0, 0, 0, 0, 0, 0, 0,  10'h000, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0,  10'h000, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0,  10'h000, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0,  10'h000, 0, 0);
        cyc(1, 1, 1, 0, 0, 0, 0,  10'h000, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0,  10'h080, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 0,  10'h081, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 0,  10'h082, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 0,  10'h083, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 0,  10'h084, 1, 0);
        cyc(1, 0, 0, 0, 1, 0, 3,  10'h085, 1, 0);
        cyc(1, 0, 0, 0, 1, 1, 6,  10'h086, 1, 0);
        cyc(1, 0, 0, 0, 1, 1, 3,  10'h085, 1, 0);
        cyc(1, 0, 0, 0, 1, 1, 7,  10'h0A0, 1, 0);
        cyc(1, 0, 0, 0, 1, 1, 8,  10'h0A0, 1, 0);
        cyc(1, 0, 0, 1, 1, 1, 3,  10'h090, 0, 0);
        cyc(1, 0, 0, 1, 0, 0, 0,  10'h090, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0,  10'h090, 1, 0);
        cyc(1, 0, 0, 0, 1, 1, 4,  10'h091, 1, 0);
        cyc(1, 0, 0, 1, 0, 0, 0,  10'h0A2, 0, 0);
        cyc(1, 0, 0, 0, 1, 1, 3,  10'h0A2, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 0,  10'h0A2, 0, 1);
        cyc(1, 1, 2, 0, 0, 0, 0,  10'h0A2, 0, 1);
        cyc(1, 1, 1, 0, 0, 0, 0,  10'h100, 1, 0);
        cyc(1, 0, 0, 0, 1, 1, 31, 10'h101, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 0,  10'h3FF, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 0,  10'h000, 1, 0);
        cyc(1, 0, 0, 0, 1, 1, 9,  10'h001, 1, 0);
        cyc(1, 0, 0, 1, 0, 0, 0,  10'h025, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0,  10'h000, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0,  10'h000, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0,  10'h000, 0, 0);
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge Clk);
        if (sb.size() > 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
